// File: rtl/raddr_empty_gray.sv
// raddr_empty_gray: FIFO read-side pointer, registered empty/almost-empty/level flags.
// Define RADDR_UNDERFLOW_FLAG_EN to build the sticky underflow_err register.
module raddr_empty_gray #(
  parameter int ADDR_WIDTH    = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  rclk,
  input  logic                  r_rst,
  input  logic                  re,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_ack,
  output logic                  underflow_err
);
  localparam int W = ADDR_WIDTH + 1;
  logic [W-1:0] rbin_q, rbin_d, rptr_gray_q, rptr_gray_d, rd_level_q, rd_level_d, wbin;
  logic         empty_q, empty_d, almost_empty_q, almost_empty_d;
  assign rd_ack = re & ~empty_q;
  always_comb begin
    wbin[W-1] = wptr_gray_sync[W-1];
    for (int i = W - 2; i >= 0; i--) wbin[i] = wbin[i+1] ^ wptr_gray_sync[i];
    rbin_d         = rbin_q + W'(rd_ack);
    rptr_gray_d    = rbin_d ^ (rbin_d >> 1);
    rd_level_d     = wbin - rbin_d;
    empty_d        = rptr_gray_d == wptr_gray_sync;
    almost_empty_d = rd_level_d <= W'(AEMPTY_THRESH);
  end
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      rbin_q         <= '0;
      rptr_gray_q    <= '0;
      rd_level_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      rbin_q         <= rbin_d;
      rptr_gray_q    <= rptr_gray_d;
      rd_level_q     <= rd_level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
    end
  end
`ifdef RADDR_UNDERFLOW_FLAG_EN
  logic underflow_q, underflow_d;
  assign underflow_d = underflow_q | (re & empty_q);
  always_ff @(posedge rclk) underflow_q <= r_rst ? 1'b0 : underflow_d;
  assign underflow_err = underflow_q;
`else
  assign underflow_err = 1'b0;
`endif
  assign raddr        = rbin_q[ADDR_WIDTH-1:0];
  assign rptr_gray    = rptr_gray_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_level     = rd_level_q;
endmodule
